// File: rtl/kw11p_pkg.sv
// KW11P programmable clock: shared register map and CSR field layout.
// Build option KW11P_EXT_CLK_EN enables the external count source.
package kw11p_pkg;

  localparam logic [1:0] OFF_CSR = 2'd0;
  localparam logic [1:0] OFF_CSB = 2'd1;
  localparam logic [1:0] OFF_CTR = 2'd2;
  localparam logic [1:0] OFF_NUL = 2'd3;

  localparam int CSR_ERR     = 15;
  localparam int CSR_DONE    = 7;
  localparam int CSR_IE      = 6;
  localparam int CSR_FIX     = 5;
  localparam int CSR_UP      = 4;
  localparam int CSR_REP     = 3;
  localparam int CSR_RATE_LO = 1;
  localparam int CSR_RUN     = 0;

  typedef enum logic [1:0] {
    RATE_100K = 2'b00,
    RATE_10K  = 2'b01,
    RATE_LINE = 2'b10,
    RATE_EXT  = 2'b11
  } rate_e;

endpackage

// File: rtl/kw11p_prescaler.sv
// KW11P free-running rate dividers: 100 kHz, 10 kHz and line pulses.
// Every pulse is one clock wide; RUN has no effect on the chain.
module kw11p_prescaler #(
  parameter int CLKREF  = 50000000,
  parameter int LINE_HZ = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_100k,
  output logic tick_10k,
  output logic tick_line
);

  localparam int DIV_F = CLKREF / 100000;
  localparam int DIV_L = CLKREF / LINE_HZ;
  localparam int W_F   = (DIV_F > 1) ? $clog2(DIV_F) : 1;
  localparam int W_L   = (DIV_L > 1) ? $clog2(DIV_L) : 1;

  logic [W_F-1:0] f_q;
  logic [3:0]     d_q;
  logic [W_L-1:0] l_q;

  assign tick_100k = (f_q == W_F'(DIV_F - 1));
  assign tick_10k  = tick_100k && (d_q == 4'd9);
  assign tick_line = (l_q == W_L'(DIV_L - 1));

  // divider counters wrap on their own terminal count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_q <= '0;
      d_q <= '0;
      l_q <= '0;
    end else begin
      f_q <= tick_100k ? '0 : f_q + 1'b1;
      if (tick_100k)
        d_q <= (d_q == 4'd9) ? 4'd0 : d_q + 4'd1;
      l_q <= tick_line ? '0 : l_q + 1'b1;
    end
  end

endmodule

// File: rtl/kw11p.sv
// KW11P programmable real-time clock with Wishbone register access.
// Define KW11P_EXT_CLK_EN to count synchronised ext_clk edges at RATE=11.
module kw11p
  import kw11p_pkg::*;
#(
  parameter int          CLKREF   = 50000000,
  parameter int          LINE_HZ  = 50,
  parameter int          CTR_W    = 16,
  parameter logic [15:0] BASE_ADR = 16'o172540,
  parameter logic [8:0]  VECTOR   = 9'o104
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq,
  input  logic        istb,
  output logic [8:0]  ivec,
  input  logic        ext_clk
);

  logic [CTR_W-1:0] csb_q, csb_d, ctr_q, ctr_d, ctr_step;
  logic             err_q, err_d, done_q, done_d;
  logic             ie_q, ie_d, up_q, up_d;
  logic             rep_q, rep_d, run_q, run_d;
  logic             irq_q, irq_d, ack_q;
  rate_e            rate_q, rate_d;
  logic [15:0]      dat_q, dat_d, rdata, csb16, csb_w;
  logic [1:0]       off;
  logic             sel, acc, wr, rd;
  logic             wr_csr, wr_csb, rd_csr;
  logic             t100k, t10k, tline, ext_pulse, src_pulse;
  logic             fix_tick, tick, evt;
  logic             unused_adr0;

  kw11p_prescaler #(
    .CLKREF  (CLKREF),
    .LINE_HZ (LINE_HZ)
  ) u_pre (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .tick_100k (t100k),
    .tick_10k  (t10k),
    .tick_line (tline)
  );

`ifdef KW11P_EXT_CLK_EN
  logic [2:0] sync_q;

  // two sync flops plus one edge-detect flop
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], ext_clk};
  end

  assign ext_pulse = sync_q[1] & ~sync_q[2];
`else
  logic unused_ext;
  assign unused_ext = ext_clk;
  assign ext_pulse  = 1'b0;
`endif

  assign unused_adr0 = wb_adr_i[0];

  assign off    = wb_adr_i[2:1];
  assign sel    = wb_cyc_i & wb_stb_i &
                  (wb_adr_i[15:3] == BASE_ADR[15:3]);
  assign acc    = sel & ~ack_q;
  assign wr     = acc & wb_we_i;
  assign rd     = acc & ~wb_we_i;
  assign wr_csr = wr & (off == OFF_CSR) & wb_sel_i[0];
  assign wr_csb = wr & (off == OFF_CSB) & (|wb_sel_i);
  assign rd_csr = rd & (off == OFF_CSR);

  // pick the count source selected by RATE
  always_comb begin
    src_pulse = 1'b0;
    unique case (rate_q)
      RATE_100K: src_pulse = t100k;
      RATE_10K:  src_pulse = t10k;
      RATE_LINE: src_pulse = tline;
      RATE_EXT:  src_pulse = ext_pulse;
    endcase
  end

  // a CSB write in the same cycle swallows the tick
  assign fix_tick = wr_csr & wb_dat_i[CSR_FIX] & ~run_q;
  assign tick     = ((run_q & src_pulse) | fix_tick) & ~wr_csb;
  assign ctr_step = up_q ? ctr_q + 1'b1 : ctr_q - 1'b1;
  assign evt      = tick & (ctr_step == '0);

  // readback mux, zero-extended, FIX always reads 0
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CSR: begin
        rdata[CSR_ERR]            = err_q;
        rdata[CSR_DONE]           = done_q;
        rdata[CSR_IE]             = ie_q;
        rdata[CSR_UP]             = up_q;
        rdata[CSR_REP]            = rep_q;
        rdata[CSR_RATE_LO +: 2]   = rate_q;
        rdata[CSR_RUN]            = run_q;
      end
      OFF_CSB: rdata = 16'(csb_q);
      OFF_CTR: rdata = 16'(ctr_q);
      default: rdata = '0;
    endcase
  end

  // next-state: bus writes, counting, event flags and irq
  always_comb begin
    ie_d   = ie_q;
    up_d   = up_q;
    rep_d  = rep_q;
    rate_d = rate_q;
    run_d  = run_q;
    csb_d  = csb_q;
    ctr_d  = ctr_q;
    done_d = done_q;
    err_d  = err_q;
    irq_d  = irq_q;
    csb16  = 16'(csb_q);
    csb_w  = {wb_sel_i[1] ? wb_dat_i[15:8] : csb16[15:8],
              wb_sel_i[0] ? wb_dat_i[7:0]  : csb16[7:0]};
    if (wr_csr) begin
      ie_d   = wb_dat_i[CSR_IE];
      up_d   = wb_dat_i[CSR_UP];
      rep_d  = wb_dat_i[CSR_REP];
      rate_d = rate_e'(wb_dat_i[CSR_RATE_LO +: 2]);
      run_d  = wb_dat_i[CSR_RUN];
    end
    if (wr_csb) begin
      csb_d = csb_w[CTR_W-1:0];
      ctr_d = csb_w[CTR_W-1:0];
    end else if (tick) begin
      ctr_d = evt ? csb_q : ctr_step;
    end
    if (evt) begin
      done_d = 1'b1;
      if (!rd_csr) err_d = err_q | done_q;
      if (!rep_q)  run_d = 1'b0;
    end else if (rd_csr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (evt & ie_q)       irq_d = 1'b1;
    else if (istb | ~ie_q) irq_d = 1'b0;
    dat_d = rd ? rdata : 16'd0;
  end

  // register state, all cleared by reset
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ie_q   <= 1'b0;
      up_q   <= 1'b0;
      rep_q  <= 1'b0;
      rate_q <= RATE_100K;
      run_q  <= 1'b0;
      csb_q  <= '0;
      ctr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      up_q   <= up_d;
      rep_q  <= rep_d;
      rate_q <= rate_d;
      run_q  <= run_d;
      csb_q  <= csb_d;
      ctr_q  <= ctr_d;
      done_q <= done_d;
      err_q  <= err_d;
      irq_q  <= irq_d;
      ack_q  <= sel & ~ack_q;
      dat_q  <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? dat_q : 16'd0;
  assign irq      = irq_q;
  assign ivec     = VECTOR;

endmodule
